// File: rtl/trace_link_arbiter_pkg.sv
// Shared constants and state encoding for the trace link arbiter and its picker.
package trace_link_arbiter_pkg;

    localparam int LEN_LSB_DEF = 22;
    localparam int LEN_W_DEF   = 8;
    localparam int CNT_W       = 32;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/trace_link_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr+1, wrapping mod NUM_IN.
module trace_rr_pick #(
    parameter int NUM_IN = 4,
    parameter int PTR_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic              gnt_val,
    output logic [PTR_W-1:0]  gnt_idx
);

    int idx;

    // Scan from the farthest candidate back to ptr+1 so the nearest requester wins.
    always_comb begin
        gnt_val = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = NUM_IN; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_IN;
            if (req[PTR_W'(idx)]) begin
                gnt_val = 1'b1;
                gnt_idx = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/trace_link_arbiter.sv
// Packet-atomic round-robin arbiter sharing one 64-bit val/yum trace link among NUM_IN taps.
// Optional saturating flit/stall counters are built when TRACE_ARB_STATS_EN is defined.
module trace_link_arbiter
    import trace_link_arbiter_pkg::*;
#(
    parameter int NUM_IN  = 4,
    parameter int LEN_LSB = LEN_LSB_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int PTR_W   = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*64-1:0]    din_msg,
    input  logic [NUM_IN-1:0]       din_val,
    output logic [NUM_IN-1:0]       din_yum,
    output logic [63:0]             dout_msg,
    output logic                    dout_val,
    input  logic                    dout_yum,
    output logic [NUM_IN*CNT_W-1:0] stat_flits,
    output logic [CNT_W-1:0]        stat_stall
);

    arb_state_e                state;
    logic [PTR_W-1:0]          ptr;
    logic [PTR_W-1:0]          lock_idx;
    logic [LEN_W-1:0]          remaining;
    logic [NUM_IN-1:0][63:0]   din_arr;
    logic                      pick_val;
    logic [PTR_W-1:0]          pick_idx;
    logic                      sel_act;
    logic [PTR_W-1:0]          sel_idx;
    logic                      xfer;
    logic [LEN_W-1:0]          hdr_len;

    assign din_arr = din_msg;

    trace_rr_pick #(.NUM_IN(NUM_IN), .PTR_W(PTR_W)) u_pick (
        .req     (din_val),
        .ptr     (ptr),
        .gnt_val (pick_val),
        .gnt_idx (pick_idx)
    );

    // While locked the owner stays selected even if it bubbles, so the link stalls.
    assign sel_act  = (state == ARB_LOCK) || pick_val;
    assign sel_idx  = (state == ARB_LOCK) ? lock_idx : pick_idx;
    assign dout_val = sel_act && din_val[sel_idx];
    assign dout_msg = sel_act ? din_arr[sel_idx] : 64'h0;
    assign xfer     = dout_val && dout_yum;
    assign hdr_len  = dout_msg[LEN_LSB +: LEN_W];

    always_comb begin
        din_yum = '0;
        if (xfer) din_yum[sel_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            ptr       <= PTR_W'(NUM_IN - 1);
            lock_idx  <= '0;
            remaining <= '0;
        end else if (xfer) begin
            case (state)
                ARB_IDLE: begin
                    if (hdr_len == '0) begin
                        ptr <= sel_idx;
                    end else begin
                        state     <= ARB_LOCK;
                        lock_idx  <= sel_idx;
                        remaining <= hdr_len;
                    end
                end
                ARB_LOCK: begin
                    remaining <= remaining - 1'b1;
                    if (remaining == LEN_W'(1)) begin
                        state <= ARB_IDLE;
                        ptr   <= lock_idx;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef TRACE_ARB_STATS_EN
    logic [CNT_W-1:0] flits_q [NUM_IN];
    logic [CNT_W-1:0] stall_q;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_stat
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                flits_q[i] <= '0;
            else if (din_yum[i] && (flits_q[i] != '1))
                flits_q[i] <= flits_q[i] + 1'b1;
        end
        assign stat_flits[i*CNT_W +: CNT_W] = flits_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= '0;
        else if (dout_val && !dout_yum && (stall_q != '1))
            stall_q <= stall_q + 1'b1;
    end
    assign stat_stall = stall_q;
`else
    assign stat_flits = '0;
    assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_trace_link_arbiter.sv
// Directed bench for trace_link_arbiter: single packet, round-robin, atomicity, back-pressure, reset, max length.
module tb_trace_link_arbiter;

    localparam int N = 4;
`ifdef TRACE_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N*64-1:0]   din_msg;
    logic [N-1:0]      din_val;
    logic [N-1:0]      din_yum;
    logic [63:0]       dout_msg;
    logic              dout_val;
    logic              dout_yum;
    logic [N*32-1:0]   stat_flits;
    logic [31:0]       stat_stall;

    int n_chk  = 0;
    int n_pass = 0;

    trace_link_arbiter #(.NUM_IN(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_msg    (din_msg),
        .din_val    (din_val),
        .din_yum    (din_yum),
        .dout_msg   (dout_msg),
        .dout_val   (dout_val),
        .dout_yum   (dout_yum),
        .stat_flits (stat_flits),
        .stat_stall (stat_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] hdr(input int len, input int id);
        return (64'(id) << 48) | (64'(len & 255) << 22);
    endfunction

    function automatic logic [63:0] pl(input int id, input int n);
        return 64'hA000_0000_0000_0000 | (64'(id) << 48) | 64'(n);
    endfunction

    task automatic set_msg(input int i, input logic [63:0] m);
        din_msg[64*i +: 64] = m;
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 1 more unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        din_val  = '0;
        din_msg  = '0;
        dout_yum = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int c1, cother;
        din_msg  = '0;
        din_val  = '0;
        dout_yum = 1'b0;
        rst_n    = 1'b1;
        #2;
        do_reset();

        // Reset state
        settle();
        chk("rst_dout_val", 128'(dout_val), 128'(0));
        chk("rst_dout_msg", 128'(dout_msg), 128'(0));
        chk("rst_din_yum",  128'(din_yum),  128'(0));
        chk("rst_stat_flits", 128'(stat_flits), 128'(0));
        chk("rst_stat_stall", 128'(stat_stall), 128'(0));
        tick();

        // Single packet from input 0, len=3
        din_val  = 4'b0001;
        dout_yum = 1'b1;
        set_msg(0, hdr(3, 0));
        for (int k = 0; k < 4; k++) begin
            if (k > 0) set_msg(0, pl(0, k));
            settle();
            chk($sformatf("sp_yum%0d", k), 128'(din_yum), 128'(4'b0001));
            chk($sformatf("sp_msg%0d", k), 128'(dout_msg), 128'(k == 0 ? hdr(3, 0) : pl(0, k)));
            tick();
        end
        din_val = '0;
        settle();
        chk("sp_idle_val", 128'(dout_val), 128'(0));
        tick();

        // Round-robin with len=0 headers; ptr=0 so order starts at 1
        din_val = 4'b1111;
        for (int i = 0; i < N; i++) set_msg(i, hdr(0, i));
        for (int k = 0; k < 8; k++) begin
            settle();
            chk($sformatf("rr_%0d", k), 128'(din_yum), 128'(4'b0001 << ((k + 1) % 4)));
            tick();
        end

        // Packet atomicity: input 1 len=2, input 0 requests mid-packet
        din_val = 4'b0010;
        set_msg(1, hdr(2, 1));
        settle();
        chk("at_hdr", 128'(din_yum), 128'(4'b0010));
        tick();
        din_val = 4'b0011;
        set_msg(1, pl(1, 1));
        settle();
        chk("at_p1", 128'(din_yum), 128'(4'b0010));
        chk("at_p1_msg", 128'(dout_msg), 128'(pl(1, 1)));
        tick();
        set_msg(1, pl(1, 2));
        settle();
        chk("at_p2", 128'(din_yum), 128'(4'b0010));
        tick();
        din_val = 4'b1001;
        settle();
        chk("at_next3", 128'(din_yum), 128'(4'b1000));
        tick();
        din_val = 4'b0001;
        settle();
        chk("at_next0", 128'(din_yum), 128'(4'b0001));
        tick();

        // Back-pressure and bubbles on input 2, len=3
        do_reset();
        din_val  = 4'b0100;
        dout_yum = 1'b1;
        set_msg(2, hdr(3, 2));
        settle();
        chk("bp_hdr", 128'(din_yum), 128'(4'b0100));
        tick();
        set_msg(2, pl(2, 1));
        dout_yum = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk($sformatf("bp_val%0d", k), 128'(dout_val), 128'(1));
            chk($sformatf("bp_msg%0d", k), 128'(dout_msg), 128'(pl(2, 1)));
            chk($sformatf("bp_yum%0d", k), 128'(din_yum), 128'(0));
            tick();
        end
        dout_yum = 1'b1;
        settle();
        chk("bp_p1", 128'(din_yum), 128'(4'b0100));
        tick();
        chk("bp_stall", 128'(stat_stall), 128'(STATS ? 5 : 0));
        din_val = 4'b1001;
        set_msg(0, hdr(0, 0));
        set_msg(3, hdr(0, 3));
        for (int k = 0; k < 2; k++) begin
            settle();
            chk($sformatf("bub_val%0d", k), 128'(dout_val), 128'(0));
            chk($sformatf("bub_yum%0d", k), 128'(din_yum), 128'(0));
            tick();
        end
        din_val = 4'b1101;
        set_msg(2, pl(2, 2));
        settle();
        chk("bp_p2", 128'(din_yum), 128'(4'b0100));
        tick();
        set_msg(2, pl(2, 3));
        settle();
        chk("bp_p3", 128'(din_yum), 128'(4'b0100));
        tick();
        chk("bp_flits", 128'(stat_flits), STATS ? (128'(4) << 64) : 128'(0));
        din_val = 4'b1001;
        settle();
        chk("bp_next3", 128'(din_yum), 128'(4'b1000));
        tick();
        chk("bp_stall2", 128'(stat_stall), 128'(STATS ? 5 : 0));

        // Reset mid-packet: input 1 len=5, header + 2 payloads then reset
        din_val = 4'b0010;
        set_msg(1, hdr(5, 1));
        settle();
        chk("rm_hdr", 128'(din_yum), 128'(4'b0010));
        tick();
        for (int k = 1; k <= 2; k++) begin
            set_msg(1, pl(1, k));
            settle();
            chk($sformatf("rm_p%0d", k), 128'(din_yum), 128'(4'b0010));
            tick();
        end
        rst_n    = 1'b0;
        dout_yum = 1'b0;
        din_val  = 4'b0011;
        set_msg(0, hdr(0, 0));
        set_msg(1, pl(1, 3));
        settle();
        chk("rm_in_rst_msg", 128'(dout_msg), 128'(hdr(0, 0)));
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        dout_yum = 1'b1;
        settle();
        chk("rm_after_yum", 128'(din_yum), 128'(4'b0001));
        tick();

        // Max length: input 1 len=255 while all others keep requesting
        do_reset();
        dout_yum = 1'b1;
        din_val  = 4'b0010;
        for (int i = 0; i < N; i++) set_msg(i, hdr(0, i));
        set_msg(1, hdr(255, 1));
        c1 = 0;
        cother = 0;
        for (int k = 0; k < 256; k++) begin
            if (k > 0) begin
                din_val = 4'b1111;
                set_msg(1, pl(1, k));
            end
            settle();
            if (din_yum == 4'b0010) c1++;
            else cother++;
            tick();
        end
        chk("ml_count1", 128'(c1), 128'(256));
        chk("ml_other", 128'(cother), 128'(0));
        chk("ml_flits", 128'(stat_flits), STATS ? (128'(256) << 32) : 128'(0));
        settle();
        chk("ml_next2", 128'(din_yum), 128'(4'b0100));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
